// File: rtl/ebpf_data_mem.sv
// ----------------------------------------------------------------------------
// ebpf_data_mem
//   Byte-addressable, little-endian data memory for an eBPF core. Storage is
//   2**DEPTH_LOG2 words of 64 bits. Loads and stores of 1/2/4/8 bytes run at
//   one request per cycle and answer one cycle after acceptance. Misaligned
//   or out-of-range requests leave memory untouched and answer with an error.
//
//   Optional feature (macro EBPF_MEM_XADD_EN):
//     Enables atomic fetch-and-add (W and DW sizes only). It uses a
//     read-modify-write XADD state and answers two cycles after acceptance
//     with the old value. Without the macro, any request with req_xadd=1 is
//     answered one cycle after acceptance with rsp_err=1.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst        : synchronous active-high reset (memory contents are kept)
//   req_valid  : request present
//   req_ready  : request accepted this cycle when req_valid is also high
//   req_write  : 1 = store, 0 = load
//   req_xadd   : atomic add, takes precedence over req_write
//   req_size   : 0=B, 1=H, 2=W, 3=DW
//   req_addr   : byte address
//   req_wdata  : store data / addend, low-order bytes used
//   rsp_valid  : one-cycle response pulse
//   rsp_rdata  : load data / old value, zero-extended; held until next response
//   rsp_err    : request faulted; held until next response
// ----------------------------------------------------------------------------
module ebpf_data_mem #(
    parameter int DEPTH_LOG2  = 5,
    parameter int BYTE_ADDR_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic                   req_xadd,
    input  logic [1:0]             req_size,
    input  logic [BYTE_ADDR_W-1:0] req_addr,
    input  logic [63:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [63:0]            rsp_rdata,
    output logic                   rsp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TOP   = DEPTH_LOG2 + 3;  // first address bit beyond the array

`ifdef EBPF_MEM_XADD_EN
    typedef enum logic [0:0] {IDLE, XADD} state_t;
`else
    typedef enum logic [0:0] {IDLE} state_t;
`endif

    // Byte enables of an access of the given size, before lane shifting.
    function automatic logic [7:0] size_be(input logic [1:0] size);
        case (size)
            2'd0:    size_be = 8'h01;
            2'd1:    size_be = 8'h03;
            2'd2:    size_be = 8'h0F;
            default: size_be = 8'hFF;
        endcase
    endfunction

    // Value mask of an access of the given size (also the add modulus).
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    logic [63:0]           mem [DEPTH];

    state_t                state_q;
    state_t                state_d;

    logic [DEPTH_LOG2-1:0] idx;
    logic [2:0]            lane;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  xadd_size_ok;
    logic                  req_err;
    logic                  accept;
    logic                  go_xadd;
    logic [63:0]           rd_val;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic [7:0]            mem_be;
    logic [63:0]           mem_wdata;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign idx  = req_addr[DEPTH_LOG2+2:3];
    assign lane = req_addr[2:0];

    always_comb begin
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = lane[0];
            2'd2:    misaligned = |lane[1:0];
            default: misaligned = |lane;
        endcase
    end

    assign out_of_range = |req_addr[BYTE_ADDR_W-1:TOP];

`ifdef EBPF_MEM_XADD_EN
    assign xadd_size_ok = req_size[1];  // W or DW
`else
    assign xadd_size_ok = 1'b0;         // every xadd is illegal
`endif

    assign req_err   = misaligned | out_of_range | (req_xadd & ~xadd_size_ok);
    assign req_ready = (state_q == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;
    assign go_xadd   = accept & req_xadd & ~req_err;

    // Addressed bytes of the current request, zero-extended.
    assign rd_val = (mem[idx] >> {lane, 3'b000}) & size_mask(req_size);

`ifdef EBPF_MEM_XADD_EN
    // ------------------------------------------------------------------
    // XADD operand capture and read-modify-write datapath
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] x_idx;
    logic [2:0]            x_lane;
    logic [1:0]            x_size;
    logic [63:0]           x_addend;
    logic [63:0]           x_old;
    logic [63:0]           x_sum;

    always_ff @(posedge clk) begin
        if (go_xadd) begin
            x_idx    <= idx;
            x_lane   <= lane;
            x_size   <= req_size;
            x_addend <= req_wdata;
        end
    end

    assign x_old = (mem[x_idx] >> {x_lane, 3'b000}) & size_mask(x_size);
    assign x_sum = (x_old + x_addend) & size_mask(x_size);
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: state and other flops use non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef EBPF_MEM_XADD_EN
            IDLE:    state_d = go_xadd ? XADD : IDLE;
            XADD:    state_d = IDLE;
`else
            IDLE:    state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory write port: plain stores on acceptance, XADD in its own state
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = idx;
        mem_be    = 8'h00;
        mem_wdata = 64'h0;
        if (accept && req_write && !req_xadd && !req_err) begin
            mem_we    = 1'b1;
            mem_be    = size_be(req_size) << lane;
            mem_wdata = req_wdata << {lane, 3'b000};
        end
`ifdef EBPF_MEM_XADD_EN
        // Reset in the XADD cycle aborts the write.
        if (state_q == XADD && !rst) begin
            mem_we    = 1'b1;
            mem_widx  = x_idx;
            mem_be    = size_be(x_size) << x_lane;
            mem_wdata = x_sum << {x_lane, 3'b000};
        end
`endif
    end

    // NOTE: the storage array has no reset; its contents survive rst and
    // it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (mem_be[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response: pulse on rsp_valid, data/error held until next response
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept && !go_xadd) begin
                rsp_valid <= 1'b1;
                rsp_err   <= req_err;
                rsp_rdata <= (req_err || req_write || req_xadd) ? 64'h0 : rd_val;
            end
`ifdef EBPF_MEM_XADD_EN
            else if (state_q == XADD) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= x_old;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ebpf_data_mem.sv
// ----------------------------------------------------------------------------
// tb_ebpf_data_mem
//   Self-checking bench for ebpf_data_mem (DEPTH_LOG2=5, BYTE_ADDR_W=64).
//   A table of back-to-back load/store vectors is driven first, then hand
//   sequences for xadd (either build), reset abort and streaming loads.
//   Expected responses go into a scoreboard queue when a request is driven;
//   a monitor pops and compares them, including the response cycle.
// ----------------------------------------------------------------------------
module tb_ebpf_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_xadd;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    ebpf_data_mem #(.DEPTH_LOG2(5), .BYTE_ADDR_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_xadd  (req_xadd),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
        string       lbl;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, DW = 2'd3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one request at a negedge; lat = 0 means no response is expected.
    task automatic issue(input logic wr, input logic xd, input logic [1:0] sz,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] er, input logic ee,
                         input int lat, input string lbl);
        exp_t e;
        @(negedge clk);
        check({lbl, "_ready"}, {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1;
        req_write = wr;
        req_xadd  = xd;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        if (lat > 0) begin
            e.rdata = er;
            e.err   = ee;
            e.due   = cyc + lat;
            e.lbl   = lbl;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_xadd  = 1'b0;
        req_wdata = 64'h0;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", {63'h0, rsp_valid}, 64'h0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.lbl, "_rdata"}, rsp_rdata, e.rdata);
                    check({e.lbl, "_err"}, {63'h0, rsp_err}, {63'h0, e.err});
                    check({e.lbl, "_cycle"}, 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_xadd  = 1'b0;
        req_size  = 2'd0;
        req_addr  = 64'h0;
        req_wdata = 64'h0;

        // Back-to-back load/store vectors: {wr, size, addr, wdata, rdata, err}
        vecs.push_back('{1'b1, DW, 64'h00, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0});
        vecs.push_back('{1'b1, DW, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 1'b0});
        vecs.push_back('{1'b0, B,  64'h13, 64'h0, 64'h55, 1'b0});
        vecs.push_back('{1'b0, H,  64'h16, 64'h0, 64'h1122, 1'b0});
        vecs.push_back('{1'b1, W,  64'h14, 64'hFFFF_FFFF, 64'h0, 1'b0});
        vecs.push_back('{1'b0, DW, 64'h10, 64'h0, 64'hFFFF_FFFF_5566_7788, 1'b0});
        vecs.push_back('{1'b0, W,  64'h02, 64'h0, 64'h0, 1'b1});
        vecs.push_back('{1'b1, B,  64'h100, 64'hEE, 64'h0, 1'b1});
        vecs.push_back('{1'b0, DW, 64'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0});
        vecs.push_back('{1'b0, DW, 64'h10, 64'h0, 64'hFFFF_FFFF_5566_7788, 1'b0});
        vecs.push_back('{1'b1, DW, 64'h20, 64'h0, 64'h0, 1'b0});
        vecs.push_back('{1'b1, B,  64'h21, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0});
        vecs.push_back('{1'b0, H,  64'h20, 64'h0, 64'hAB00, 1'b0});
        vecs.push_back('{1'b1, H,  64'h21, 64'h7777, 64'h0, 1'b1});
        vecs.push_back('{1'b0, H,  64'h20, 64'h0, 64'hAB00, 1'b0});
        vecs.push_back('{1'b1, H,  64'h16, 64'h1234_ABCD, 64'h0, 1'b0});
        vecs.push_back('{1'b0, DW, 64'h10, 64'h0, 64'hABCD_FFFF_5566_7788, 1'b0});
        vecs.push_back('{1'b1, DW, 64'hF8, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0});
        vecs.push_back('{1'b0, W,  64'hFC, 64'h0, 64'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, W,  64'hF8, 64'h0, 64'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b0, DW, 64'hFC, 64'h0, 64'h0, 1'b1});
        vecs.push_back('{1'b0, B,  64'h8000_0000_0000_0010, 64'h0, 64'h0, 1'b1});
        vecs.push_back('{1'b0, B,  64'h10, 64'h0, 64'h88, 1'b0});

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {63'h0, req_ready}, 64'h0);
        check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check("rst_rsp_rdata", rsp_rdata, 64'h0);
        check("rst_rsp_err", {63'h0, rsp_err}, 64'h0);
        rst = 1'b0;

        // Table, driven back-to-back
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].wr, 1'b0, vecs[i].size, vecs[i].addr,
                  vecs[i].wr ? vecs[i].wdata : 64'($urandom),
                  vecs[i].exp_rdata, vecs[i].exp_err, 1, $sformatf("vec%0d", i));
        end
        idle();

`ifdef EBPF_MEM_XADD_EN
        // xadd W with carry out of the low word: upper bytes untouched
        issue(1'b1, 1'b0, DW, 64'h08, 64'h1234_5678_FFFF_FFFF, 64'h0, 1'b0, 1, "st08");
        issue(1'b0, 1'b1, W, 64'h08, 64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF, 1'b0, 2, "xaddw");
        idle();
        check("xadd_busy_ready", {63'h0, req_ready}, 64'h0);
        issue(1'b0, 1'b0, W, 64'h08, 64'h0, 64'h0, 1'b0, 1, "ld08_after_xadd");
        issue(1'b0, 1'b0, W, 64'h0C, 64'h0, 64'h1234_5678, 1'b0, 1, "ld0c_after_xadd");
        issue(1'b0, 1'b1, DW, 64'h08, 64'h1, 64'h1234_5678_0000_0000, 1'b0, 2, "xadddw");
        idle();
        issue(1'b0, 1'b0, DW, 64'h08, 64'h0, 64'h1234_5678_0000_0001, 1'b0, 1, "ld08_dw");
        issue(1'b0, 1'b1, H, 64'h08, 64'h1, 64'h0, 1'b1, 1, "xaddh_err");
        issue(1'b0, 1'b0, DW, 64'h08, 64'h0, 64'h1234_5678_0000_0001, 1'b0, 1, "ld08_after_h");
        idle();

        // Reset raised in the XADD cycle aborts it
        issue(1'b0, 1'b1, W, 64'h08, 64'h5, 64'h0, 1'b0, 0, "xadd_abort");
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        rst = 1'b0;
        #1;
        check("abort_release_ready", {63'h0, req_ready}, 64'h1);
        issue(1'b0, 1'b0, DW, 64'h08, 64'h0, 64'h1234_5678_0000_0001, 1'b0, 1, "ld08_after_abort");
        idle();
`else
        // xadd is illegal in this build, even with req_write set
        issue(1'b1, 1'b1, DW, 64'h10, 64'h1, 64'h0, 1'b1, 1, "xadd_dw_err");
        issue(1'b0, 1'b0, DW, 64'h10, 64'h0, 64'hABCD_FFFF_5566_7788, 1'b0, 1, "ld10_after_xadd");
        issue(1'b0, 1'b1, W, 64'h10, 64'h1, 64'h0, 1'b1, 1, "xadd_w_err");
        issue(1'b0, 1'b0, W, 64'h10, 64'h0, 64'h5566_7788, 1'b0, 1, "ld10w_after_xadd");
        idle();
`endif

        // Reset mid-stream clears outputs but keeps memory
        rst = 1'b1;
        @(negedge clk);
        check("rst2_rdata", rsp_rdata, 64'h0);
        check("rst2_ready", {63'h0, req_ready}, 64'h0);
        rst = 1'b0;

        // Eight back-to-back byte loads of word 0x10
        begin
            logic [63:0] word;
            word = 64'hABCD_FFFF_5566_7788;
            for (int i = 0; i < 8; i++) begin
                issue(1'b0, 1'b0, B, 64'h10 + 64'(i), 64'h0, (word >> (8 * i)) & 64'hFF,
                      1'b0, 1, $sformatf("stream%0d", i));
            end
        end
        idle();

        // Drain: every expected response must have arrived
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
